// File: rtl/gpio_scan_capture_if.sv
// Scan-bus monitor interface: raw scan word and error clear in, reconstructed
// frame and status flags out.
interface gpio_scan_capture_if;
  logic [31:0]  gpio_0;
  logic         err_clr;
  logic [127:0] rows_flat;
  logic [63:0]  hex_flat;
  logic         frame_valid;
  logic         seq_err;
  logic         sel_err;
  logic         scan_lost;

  modport master (
    output gpio_0, err_clr,
    input  rows_flat, hex_flat, frame_valid, seq_err, sel_err, scan_lost
  );

  modport slave (
    input  gpio_0, err_clr,
    output rows_flat, hex_flat, frame_valid, seq_err, sel_err, scan_lost
  );
endinterface

// File: rtl/gpio_scan_capture.sv
// Reconstructs matrix rows and hex digits from the multiplexed GPIO scan bus,
// publishing a double-buffered frame once rows 0..7 are captured in order.
module gpio_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input  logic                 clock_50,
  input  logic                 reset_n,
  gpio_scan_capture_if.slave   bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   gpio_q, prev_q;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    exp_q, cap_idx_q;
  logic [7:0]    mask_q;
  logic [TW-1:0] tmo_q;
  logic          publish_q, frame_valid_q, seq_err_q, sel_err_q;
  logic [127:0]  rows_q;
  logic [63:0]   hex_q;
  logic [15:0]   shadow_row_q [8];
  logic [7:0]    shadow_hex_q [8];

  logic [7:0]    sel;
  logic          row_blank, row_onehot, row_invalid, same_word, stable_hit;
  logic [2:0]    row_idx;
  logic [15:0]   cols_rev;
  logic [127:0]  shadow_rows_flat;
  logic [63:0]   shadow_hex_flat;
  logic          capture, seq_hit, publish_d;
  logic [7:0]    mask_cap;

  assign sel         = gpio_q[7:0];
  assign row_blank   = (sel == 8'd0);
  assign row_onehot  = $onehot(sel);
  assign row_invalid = !row_blank && !row_onehot;
  assign same_word   = (gpio_q == prev_q);
  assign stable_hit  = row_onehot && same_word && (cnt_q == 8'(STABLE_CYCLES - 1));

  always_comb begin
    row_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (sel[k]) row_idx = 3'(k);
    end
  end

  // Column field arrives bit-reversed relative to the row data.
  for (genvar gi = 0; gi < 16; gi++) begin : g_rev
    assign cols_rev[gi] = gpio_q[23 - gi];
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_flat
    assign shadow_rows_flat[16*gi +: 16] = shadow_row_q[gi];
    assign shadow_hex_flat[8*gi +: 8]    = shadow_hex_q[gi];
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:  state_d = ARMED;
      ARMED: begin
        if (stable_hit) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (row_blank || row_invalid || (row_idx != cap_idx_q)) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = 8'd0;
    if (row_onehot && same_word) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  assign seq_hit   = capture && (row_idx != exp_q);
  assign mask_cap  = seq_hit ? (8'd1 << row_idx) : (mask_q | (8'd1 << row_idx));
  assign publish_d = capture && (row_idx == 3'd7) && (mask_cap == 8'hFF);

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gpio_q        <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      exp_q         <= '0;
      cap_idx_q     <= '0;
      mask_q        <= '0;
      tmo_q         <= '0;
      publish_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      sel_err_q     <= 1'b0;
      rows_q        <= '0;
      hex_q         <= '0;
      for (int k = 0; k < 8; k++) begin
        shadow_row_q[k] <= '0;
        shadow_hex_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      gpio_q    <= bus.gpio_0;
      prev_q    <= gpio_q;
      cnt_q     <= cnt_d;
      publish_q <= publish_d;
      seq_err_q <= (seq_err_q && !bus.err_clr) || seq_hit;
      sel_err_q <= (sel_err_q && !bus.err_clr) || row_invalid;

      if (capture) begin
        shadow_row_q[row_idx] <= cols_rev;
        shadow_hex_q[row_idx] <= gpio_q[31:24];
        mask_q                <= mask_cap;
        exp_q                 <= row_idx + 3'd1;
        cap_idx_q             <= row_idx;
      end else if (publish_q) begin
        mask_q <= '0;
      end

      frame_valid_q <= publish_q;
      if (publish_q) begin
        rows_q <= shadow_rows_flat;
        hex_q  <= shadow_hex_flat;
      end

      if (capture) tmo_q <= '0;
      else if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + TW'(1);
    end
  end

  assign bus.rows_flat   = rows_q;
  assign bus.hex_flat    = hex_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.scan_lost   = (tmo_q == TW'(TIMEOUT_CYCLES));
endmodule

// File: tb/tb_gpio_scan_capture.sv
// Directed bench for gpio_scan_capture: nominal frames, bit order, glitch
// rejection, order/select faults, timeout and asynchronous reset.
module tb_gpio_scan_capture;
  localparam int unsigned STABLE  = 16;
  localparam int unsigned TIMEOUT = 600;

  logic clock_50 = 1'b0;
  logic reset_n  = 1'b0;
  int   tests    = 0;
  int   fails    = 0;
  int   fv_count = 0;

  gpio_scan_capture_if bus_if ();

  gpio_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .bus      (bus_if)
  );

  always #5 clock_50 = ~clock_50;

  always @(posedge clock_50) if (bus_if.frame_valid) fv_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bitrev(input logic [15:0] v);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[b] = v[15 - b];
    return r;
  endfunction

  function automatic logic [15:0] nom_row(input int k);
    return 16'(k * 16'h1111);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  task automatic send_row(input int idx, input logic [15:0] raw_cols, input logic [7:0] hexv);
    bus_if.gpio_0 = {hexv, raw_cols, 8'(8'd1 << idx)};
    idle(24);
    bus_if.gpio_0 = 32'd0;
    idle(4);
  endtask

  task automatic send_nominal_row(input int k);
    send_row(k, bitrev(nom_row(k)), 8'(8'h80 | k));
  endtask

  task automatic send_nominal_frame();
    for (int k = 0; k < 8; k++) send_nominal_row(k);
    idle(4);
  endtask

  localparam logic [127:0] NOM_ROWS = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [63:0]  NOM_HEX  = 64'h8786_8584_8382_8180;

  int fv_base;

  initial begin
    bus_if.gpio_0  = 32'd0;
    bus_if.err_clr = 1'b0;
    idle(3);
    chk("reset_rows", bus_if.rows_flat, 128'd0);
    chk("reset_hex", bus_if.hex_flat, 128'd0);
    chk("reset_fv", bus_if.frame_valid, 1'b0);
    chk("reset_seq", bus_if.seq_err, 1'b0);
    chk("reset_sel", bus_if.sel_err, 1'b0);
    chk("reset_lost", bus_if.scan_lost, 1'b0);
    reset_n = 1'b1;
    idle(2);

    // Nominal frames
    send_nominal_frame();
    chk("nom_fv_once", fv_count, 1);
    chk("nom_row1", bus_if.rows_flat[31:16], 16'h1111);
    chk("nom_hex1", bus_if.hex_flat[15:8], 8'h81);
    chk("nom_rows", bus_if.rows_flat, NOM_ROWS);
    chk("nom_hex", bus_if.hex_flat, NOM_HEX);
    chk("nom_seq", bus_if.seq_err, 1'b0);
    chk("nom_lost", bus_if.scan_lost, 1'b0);
    send_nominal_frame();
    chk("nom_fv_twice", fv_count, 2);

    // Bit order
    send_row(0, 16'h0001, 8'h00);
    for (int k = 1; k < 8; k++) send_row(k, 16'h0000, 8'h00);
    idle(4);
    chk("bitord_0001", bus_if.rows_flat[15:0], 16'h8000);
    chk("bitord_hex", bus_if.hex_flat, 64'd0);
    send_row(0, 16'h8000, 8'h00);
    for (int k = 1; k < 8; k++) send_row(k, 16'h0000, 8'h00);
    idle(4);
    chk("bitord_8000", bus_if.rows_flat[15:0], 16'h0001);
    chk("bitord_fv", fv_count, 4);

    // Glitch rejection on row 3
    for (int k = 0; k < 3; k++) send_nominal_row(k);
    for (int t = 0; t < 10; t++) begin
      bus_if.gpio_0 = {8'h83, (t % 2 == 1) ? 16'hAAAA : 16'h5555, 8'h08};
      idle(8);
    end
    bus_if.gpio_0 = {8'h83, 16'h0F00, 8'h08};
    idle(24);
    bus_if.gpio_0 = 32'd0;
    idle(4);
    for (int k = 4; k < 8; k++) send_nominal_row(k);
    idle(4);
    chk("glitch_rows", bus_if.rows_flat, 128'h7777_6666_5555_4444_00F0_2222_1111_0000);
    chk("glitch_seq", bus_if.seq_err, 1'b0);
    chk("glitch_fv", fv_count, 5);

    // Order fault
    send_nominal_row(0);
    send_nominal_row(1);
    send_nominal_row(2);
    send_nominal_row(5);
    send_nominal_row(6);
    send_nominal_row(7);
    idle(4);
    chk("order_seq_set", bus_if.seq_err, 1'b1);
    chk("order_no_fv", fv_count, 5);
    send_nominal_frame();
    chk("order_clean_fv", fv_count, 6);
    chk("order_clean_rows", bus_if.rows_flat, NOM_ROWS);
    chk("order_seq_sticky", bus_if.seq_err, 1'b1);
    bus_if.err_clr = 1'b1;
    idle(1);
    bus_if.err_clr = 1'b0;
    chk("order_seq_clr", bus_if.seq_err, 1'b0);

    // Select fault
    bus_if.gpio_0 = {8'h80, 16'h1234, 8'b0001_0100};
    idle(1);
    bus_if.gpio_0 = 32'd0;
    idle(1);
    chk("sel_set", bus_if.sel_err, 1'b1);
    idle(4);
    chk("sel_sticky", bus_if.sel_err, 1'b1);
    bus_if.err_clr = 1'b1;
    idle(1);
    bus_if.err_clr = 1'b0;
    chk("sel_clr", bus_if.sel_err, 1'b0);
    send_nominal_frame();
    chk("sel_no_capture_fv", fv_count, 7);
    chk("sel_seq_clean", bus_if.seq_err, 1'b0);

    // Timeout
    idle(TIMEOUT + 20);
    chk("lost_set", bus_if.scan_lost, 1'b1);
    bus_if.gpio_0 = {8'h80, 16'h0000, 8'h01};
    idle(5);
    chk("lost_before_cap", bus_if.scan_lost, 1'b1);
    idle(19);
    chk("lost_cleared", bus_if.scan_lost, 1'b0);
    bus_if.gpio_0 = 32'd0;
    idle(4);

    // Asynchronous reset mid-frame
    send_nominal_row(1);
    send_nominal_row(2);
    send_nominal_row(3);
    chk("pre_reset_rows", bus_if.rows_flat, NOM_ROWS);
    reset_n = 1'b0;
    #1;
    chk("rst_rows", bus_if.rows_flat, 128'd0);
    chk("rst_hex", bus_if.hex_flat, 128'd0);
    chk("rst_fv", bus_if.frame_valid, 1'b0);
    chk("rst_lost", bus_if.scan_lost, 1'b0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    fv_base = fv_count;
    send_nominal_frame();
    chk("post_rst_fv", fv_count - fv_base, 1);
    chk("post_rst_rows", bus_if.rows_flat, NOM_ROWS);
    chk("post_rst_seq", bus_if.seq_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
